// File: rtl/keystream_checker.sv
// Receive-side checker for the 16-bit filtered-LFSR keystream generator.
// A local copy of the generator runs in lockstep with the valid strobe and is compared bit by bit with the input.
module keystream_checker #(
    parameter logic [15:0] INIT       = 16'hACE1,
    parameter int          LOCK_COUNT = 16,
    parameter int          LOSS_ERRS  = 4,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             expected_bit,
    output logic             locked,
    output logic             lost,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LOCKED = 2'd1,
        LOST   = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_C = 8'(LOCK_COUNT);
    localparam logic [7:0] LOSS_C = 8'(LOSS_ERRS);

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [7:0]       run_q, run_d;
    logic [7:0]       loss_q, loss_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             err_pulse_q, err_pulse_d;

    logic fb;
    logic mismatch;

    assign fb           = lfsr_q[15] ^ lfsr_q[4] ^ lfsr_q[2] ^ lfsr_q[1];
    assign expected_bit = (lfsr_q[14] & lfsr_q[11]) ^ (lfsr_q[9] & lfsr_q[6])
                        ^ (lfsr_q[15] | lfsr_q[8]) ^ lfsr_q[2];
    // Compared against the state before this edge's advance.
    assign mismatch     = bit_valid & (bit_in ^ expected_bit);

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        run_d       = run_q;
        loss_d      = loss_q;
        err_cnt_d   = err_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        err_pulse_d = 1'b0;

        if (sync) begin
            // Restart wins over a coincident valid bit; that bit is dropped.
            state_d   = HUNT;
            lfsr_d    = INIT;
            run_d     = 8'd0;
            loss_d    = 8'd0;
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end else if (bit_valid) begin
            lfsr_d      = {lfsr_q[14:0], fb};
            err_pulse_d = mismatch;
            if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 1'b1;
            if (mismatch && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;

            unique case (state_q)
                HUNT: begin
                    if (mismatch) begin
                        run_d = 8'd0;
                    end else if (run_q + 8'd1 == LOCK_C) begin
                        run_d   = 8'd0;
                        loss_d  = 8'd0;
                        state_d = LOCKED;
                    end else begin
                        run_d = run_q + 8'd1;
                    end
                end
                LOCKED: begin
                    if (!mismatch) begin
                        loss_d = 8'd0;
                    end else if (loss_q + 8'd1 == LOSS_C) begin
                        state_d = LOST;
                    end else begin
                        loss_d = loss_q + 8'd1;
                    end
                end
                LOST:    state_d = LOST;
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            lfsr_q      <= INIT;
            run_q       <= 8'd0;
            loss_q      <= 8'd0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            run_q       <= run_d;
            loss_q      <= loss_d;
            err_cnt_q   <= err_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign lost      = (state_q == LOST);
    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;
    assign bit_count = bit_cnt_q;

endmodule

// File: tb/tb_keystream_checker.sv
// Directed plus random bench for keystream_checker against a behavioural model; a narrow-counter instance covers saturation.
module tb_keystream_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sync = 1'b0;
    logic bit_valid = 1'b0;
    logic bit_in = 1'b0;

    logic        exp_bit, locked, lost, err_pulse;
    logic [15:0] err_count, bit_count;
    logic        n_exp_bit, n_locked, n_lost, n_err_pulse;
    logic [3:0]  n_err_count, n_bit_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    keystream_checker dut (
        .clk(clk), .rst_n(rst_n), .sync(sync), .bit_valid(bit_valid), .bit_in(bit_in),
        .expected_bit(exp_bit), .locked(locked), .lost(lost), .err_pulse(err_pulse),
        .err_count(err_count), .bit_count(bit_count)
    );

    keystream_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .sync(sync), .bit_valid(bit_valid), .bit_in(bit_in),
        .expected_bit(n_exp_bit), .locked(n_locked), .lost(n_lost), .err_pulse(n_err_pulse),
        .err_count(n_err_count), .bit_count(n_bit_count)
    );

    // Behavioural model: mode 0 = hunting, 1 = locked, 2 = lost.
    logic [15:0] m_lfsr;
    int          m_mode, m_run, m_loss, m_err, m_bits;
    logic        m_pulse;

    function automatic logic kbit(input logic [15:0] s);
        return (s[14] & s[11]) ^ (s[9] & s[6]) ^ (s[15] | s[8]) ^ s[2];
    endfunction

    function automatic logic [15:0] knext(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[4] ^ s[2] ^ s[1]};
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        m_lfsr = 16'hACE1; m_mode = 0; m_run = 0; m_loss = 0;
        m_err = 0; m_bits = 0; m_pulse = 1'b0;
    endtask

    task automatic model_update(input logic v, input logic b, input logic s);
        logic mm;
        if (s) begin
            model_reset();
        end else if (!v) begin
            m_pulse = 1'b0;
        end else begin
            mm = (b != kbit(m_lfsr));
            m_bits++;
            if (mm) m_err++;
            m_pulse = mm;
            if (m_mode == 0) begin
                m_run = mm ? 0 : m_run + 1;
                if (m_run == 16) begin m_mode = 1; m_run = 0; m_loss = 0; end
            end else if (m_mode == 1) begin
                m_loss = mm ? m_loss + 1 : 0;
                if (m_loss == 4) m_mode = 2;
            end
            m_lfsr = knext(m_lfsr);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".exp"},    32'(exp_bit),     32'(kbit(m_lfsr)));
        check({tag, ".locked"}, 32'(locked),      32'(m_mode == 1));
        check({tag, ".lost"},   32'(lost),        32'(m_mode == 2));
        check({tag, ".pulse"},  32'(err_pulse),   32'(m_pulse));
        check({tag, ".errs"},   32'(err_count),   32'(sat(m_err, 65535)));
        check({tag, ".bits"},   32'(bit_count),   32'(sat(m_bits, 65535)));
        check({tag, ".n_errs"}, 32'(n_err_count), 32'(sat(m_err, 15)));
        check({tag, ".n_bits"}, 32'(n_bit_count), 32'(sat(m_bits, 15)));
        check({tag, ".n_lock"}, 32'(n_locked),    32'(m_mode == 1));
    endtask

    task automatic step(input string tag, input logic v, input logic b, input logic s);
        @(negedge clk);
        bit_valid = v; bit_in = b; sync = s;
        @(posedge clk);
        model_update(v, b, s);
        #1;
        bit_valid = 1'b0; sync = 1'b0;
        check_all(tag);
    endtask

    task automatic good(input string tag);
        step(tag, 1'b1, kbit(m_lfsr), 1'b0);
    endtask

    task automatic bad(input string tag);
        step(tag, 1'b1, ~kbit(m_lfsr), 1'b0);
    endtask

    initial begin
        model_reset();
        #12 rst_n = 1'b1;
        @(negedge clk);
        check_all("reset");
        check("reset.exp1", 32'(exp_bit), 32'd1);

        // Generator opening bits for ACE1 are 1,0,0.
        step("t1.b0", 1'b1, 1'b1, 1'b0);
        step("t1.b1", 1'b1, 1'b0, 1'b0);
        step("t1.b2", 1'b1, 1'b0, 1'b0);
        check("t1.bits3", 32'(bit_count), 32'd3);
        check("t1.errs0", 32'(err_count), 32'd0);

        step("t2.sync", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            good("t2.good");
            if (i == 6) step("t2.gap", 1'b0, 1'b0, 1'b0);
            if (i == 14) check("t2.notyet", 32'(locked), 32'd0);
        end
        check("t2.locked", 32'(locked), 32'd1);

        bad("t3.one");
        check("t3.pulse", 32'(err_pulse), 32'd1);
        check("t3.still", 32'(locked), 32'd1);
        good("t3.after");
        check("t3.pulse0", 32'(err_pulse), 32'd0);
        for (int i = 0; i < 4; i++) bad("t3.burst");
        check("t3.lost", 32'(lost), 32'd1);
        check("t3.unlock", 32'(locked), 32'd0);
        for (int i = 0; i < 5; i++) good("t3.sticky");
        check("t3.sticky", 32'(lost), 32'd1);

        step("t4.syncv", 1'b1, 1'b1, 1'b1);
        check("t4.exp1", 32'(exp_bit), 32'd1);
        check("t4.bits0", 32'(bit_count), 32'd0);

        for (int i = 0; i < 20; i++) bad("t5.inv");
        check("t5.nerr", 32'(n_err_count), 32'd15);
        check("t5.nbits", 32'(n_bit_count), 32'd15);
        check("t5.nlost", 32'(n_lost), 32'd0);
        check("t5.err20", 32'(err_count), 32'd20);

        step("t6.sync", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) good("t6.good");
        bad("t6.err");
        check("t6.locked", 32'(locked), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6.rst_lock", 32'(locked), 32'd0);
        check("t6.rst_errs", 32'(err_count), 32'd0);
        check("t6.rst_bits", 32'(bit_count), 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
        check("t6.exp1", 32'(exp_bit), 32'd1);
        step("t6.first", 1'b1, 1'b1, 1'b0);
        check("t6.first_ok", 32'(err_count), 32'd0);

        // Random traffic: gappy strobe, sparse errors, an occasional restart and one forced burst.
        for (int i = 0; i < 400; i++) begin
            logic v, e, s;
            v = ($urandom % 4) != 0;
            e = ($urandom % 12) == 0;
            s = ($urandom % 150) == 0;
            step("rand", v, kbit(m_lfsr) ^ e, s);
            if (i == 250) for (int k = 0; k < 4; k++) bad("rand.burst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
